// File: rtl/mandel_scan_if.sv
// Core-side and framebuffer-side handshake bundle for mandel_scan.
// master = scanner, slave = iteration core plus framebuffer.
interface mandel_scan_if #(
    parameter int FP_WIDTH = 25,
    parameter int ITERW    = 8,
    parameter int ADDRW    = 16
);
    logic                       calc_start;
    logic signed [FP_WIDTH-1:0] calc_re;
    logic signed [FP_WIDTH-1:0] calc_im;
    logic                       calc_done;
    logic [ITERW-1:0]           calc_iter;
    logic                       px_we;
    logic [ADDRW-1:0]           px_addr;
    logic [ITERW-1:0]           px_iter;
    logic                       px_ready;

    modport master (
        output calc_start,
        output calc_re,
        output calc_im,
        input  calc_done,
        input  calc_iter,
        output px_we,
        output px_addr,
        output px_iter,
        input  px_ready
    );

    modport slave (
        input  calc_start,
        input  calc_re,
        input  calc_im,
        output calc_done,
        output calc_iter,
        input  px_we,
        input  px_addr,
        input  px_iter,
        output px_ready
    );
endinterface

// File: rtl/mandel_scan.sv
// Raster frame scanner feeding the Mandelbrot core and framebuffer.
// Optional busy-cycle counter: define MANDEL_SCAN_PERF_EN.
module mandel_scan #(
    parameter int FP_WIDTH = 25,
    parameter int FP_INT   = 4,
    parameter int ITERW    = 8,
    parameter int H_RES    = 320,
    parameter int V_RES    = 180,
    parameter int ADDRW    = $clog2(H_RES * V_RES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic signed [FP_WIDTH-1:0] re_start,
    input  logic signed [FP_WIDTH-1:0] im_start,
    input  logic signed [FP_WIDTH-1:0] step,
    output logic                       busy,
    output logic                       frame_done,
`ifdef MANDEL_SCAN_PERF_EN
    output logic [31:0]                frame_cycles,
`endif
    mandel_scan_if.master              bus
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [XW-1:0]    X_LAST = XW'(H_RES - 1);
    localparam logic [ADDRW-1:0] A_LAST = ADDRW'(H_RES * V_RES - 1);

    // Reject a fixed-point format with no fractional or no integer bits
    if (FP_INT < 1 || FP_INT >= FP_WIDTH) begin : g_fp_check
        $error("mandel_scan: FP_INT out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE
    } state_t;

    state_t                     state;
    logic [XW-1:0]              x;
    logic signed [FP_WIDTH-1:0] re0;
    logic signed [FP_WIDTH-1:0] stp;

    // Frame walk: issue, wait for the core, write, advance in raster order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            x              <= '0;
            re0            <= '0;
            stp            <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            bus.calc_start <= 1'b0;
            bus.calc_re    <= '0;
            bus.calc_im    <= '0;
            bus.px_we      <= 1'b0;
            bus.px_addr    <= '0;
            bus.px_iter    <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        re0            <= re_start;
                        stp            <= step;
                        x              <= '0;
                        bus.px_addr    <= '0;
                        bus.calc_re    <= re_start;
                        bus.calc_im    <= im_start;
                        busy           <= 1'b1;
                        bus.calc_start <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.calc_start <= 1'b0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (bus.calc_done) begin
                        bus.px_iter <= bus.calc_iter;
                        bus.px_we   <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.px_ready) begin
                        bus.px_we <= 1'b0;
                        if (bus.px_addr == A_LAST) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            bus.px_addr    <= bus.px_addr + 1'b1;
                            bus.calc_start <= 1'b1;
                            state          <= ISSUE;
                            if (x == X_LAST) begin
                                x           <= '0;
                                bus.calc_re <= re0;
                                bus.calc_im <= bus.calc_im - stp;
                            end else begin
                                x           <= x + 1'b1;
                                bus.calc_re <= bus.calc_re + stp;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MANDEL_SCAN_PERF_EN
    // Busy-cycle counter: cleared on acceptance, saturating, held when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cycles <= '0;
        end else if (state == IDLE && frame_start) begin
            frame_cycles <= '0;
        end else if (busy && frame_cycles != '1) begin
            frame_cycles <= frame_cycles + 32'd1;
        end
    end
`endif
endmodule
